// File: rtl/parking_zone_if.sv
// parking_zone_if: per-zone sensor inputs and occupancy/lamp/gate status of the parking controller
interface parking_zone_if #(
  parameter int ZONES = 2,
  parameter int CNT_W = 5
);
  logic [ZONES-1:0] entry_raw, exit_raw;
  logic [ZONES*CNT_W-1:0] count, free;
  logic [ZONES-1:0] full, empty, green, red, gate_open, reject, underflow_err;
  logic lot_full;
  modport master (
    output entry_raw, exit_raw,
    input count, free, full, empty, green, red, gate_open, reject, underflow_err, lot_full
  );
  modport slave (
    input entry_raw, exit_raw,
    output count, free, full, empty, green, red, gate_open, reject, underflow_err, lot_full
  );
endinterface

// File: rtl/parking_zone_ctrl.sv
// parking_zone_ctrl: multi-zone debounced occupancy counters with timed entry gates and status lamps
module parking_zone_ctrl #(
  parameter int ZONES = 2,
  parameter int CNT_W = 5,
  parameter int CAPACITY = 20,
  parameter int DEB_CYCLES = 4,
  parameter int GATE_CYCLES = 8
) (
  input logic clk,
  input logic reset,
  parking_zone_if.slave bus
);
  localparam int NS = 2 * ZONES;
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int TW = $clog2(GATE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);
  typedef enum logic {IDLE, OPEN} gate_t;
  logic [NS-1:0] raw, acc, acc_d, ev;
  logic [DW-1:0] deb [NS];
  logic [CNT_W-1:0] cnt [ZONES];
  logic [TW-1:0] tmr [ZONES];
  gate_t st [ZONES];
  logic [ZONES-1:0] ent, ext, en_only, ex_only, at_cap, at_zero, start, rej, err, open;
  // sensor index s < ZONES is an entry sensor, s >= ZONES the matching exit sensor
  assign raw = {bus.exit_raw, bus.entry_raw};
  assign ent = ev[ZONES-1:0];
  assign ext = ev[NS-1:ZONES];
  assign en_only = ent & ~ext;
  assign ex_only = ext & ~ent;
  assign start = ent & (ext | ~at_cap);
  always_comb begin
    for (int z = 0; z < ZONES; z++) begin
      at_cap[z] = cnt[z] == CAP;
      at_zero[z] = cnt[z] == '0;
      open[z] = st[z] == OPEN;
      bus.count[z*CNT_W +: CNT_W] = cnt[z];
      bus.free[z*CNT_W +: CNT_W] = CAP - cnt[z];
    end
  end
  assign bus.full = at_cap;
  assign bus.empty = at_zero;
  assign bus.green = ~at_cap;
  assign bus.red = at_cap;
  assign bus.gate_open = open;
  assign bus.reject = rej;
  assign bus.underflow_err = err;
  assign bus.lot_full = &at_cap;
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      acc_d <= '0;
      ev <= '0;
      rej <= '0;
      err <= '0;
      for (int s = 0; s < NS; s++) deb[s] <= '0;
      for (int z = 0; z < ZONES; z++) begin
        cnt[z] <= '0;
        tmr[z] <= '0;
        st[z] <= IDLE;
      end
    end else begin
      acc_d <= acc;
      ev <= acc & ~acc_d;
      rej <= en_only & at_cap;
      err <= err | (ex_only & at_zero);
      for (int s = 0; s < NS; s++) begin
        if (raw[s] == acc[s]) deb[s] <= '0;
        else if (deb[s] == DW'(DEB_CYCLES - 1)) begin
          acc[s] <= raw[s];
          deb[s] <= '0;
        end else deb[s] <= deb[s] + DW'(1);
      end
      for (int z = 0; z < ZONES; z++) begin
        if (en_only[z] && !at_cap[z]) cnt[z] <= cnt[z] + CNT_W'(1);
        else if (ex_only[z] && !at_zero[z]) cnt[z] <= cnt[z] - CNT_W'(1);
        if (start[z]) begin
          st[z] <= OPEN;
          tmr[z] <= TW'(GATE_CYCLES);
        end else if (st[z] == OPEN) begin
          tmr[z] <= tmr[z] - TW'(1);
          if (tmr[z] == TW'(1)) st[z] <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_parking_zone_ctrl.sv
// tb_parking_zone_ctrl: directed stimulus with a per-cycle reference model and literal checkpoints
module tb_parking_zone_ctrl;
  localparam int Z = 2, CW = 5, CAP = 20, DEB = 4, G = 8, NS = 2 * Z, HN = 8192;
  logic clk = 0, reset = 1;
  parking_zone_if #(.ZONES(Z), .CNT_W(CW)) bus ();
  parking_zone_ctrl #(.ZONES(Z), .CNT_W(CW), .CAPACITY(CAP), .DEB_CYCLES(DEB), .GATE_CYCLES(G))
    dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  function automatic void chk(string n, int a, int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", n, a, e);
    end
  endfunction
  // model: raw history per sensor, acceptance when the last DEB samples all disagree with the accepted level
  bit rh [NS][HN];
  int last_flip [NS];
  bit m_acc [NS], p1 [NS], p2 [NS];
  int m_cnt [Z], close_e [Z];
  bit m_rej [Z], m_err [Z];
  int edge_n = 0;
  bit armed = 0;
  always @(posedge clk) begin
    edge_n++;
    if (reset) begin
      armed = 1;
      for (int s = 0; s < NS; s++) begin
        m_acc[s] = 0; p1[s] = 0; p2[s] = 0; last_flip[s] = edge_n;
      end
      for (int z = 0; z < Z; z++) begin
        m_cnt[z] = 0; close_e[z] = 0; m_rej[z] = 0; m_err[z] = 0;
      end
    end else begin
      for (int z = 0; z < Z; z++) begin
        m_rej[z] = 0;
        if (p2[z] && p2[Z+z]) close_e[z] = edge_n + G;
        else if (p2[z]) begin
          if (m_cnt[z] == CAP) m_rej[z] = 1;
          else begin m_cnt[z]++; close_e[z] = edge_n + G; end
        end else if (p2[Z+z]) begin
          if (m_cnt[z] == 0) m_err[z] = 1;
          else m_cnt[z]--;
        end
      end
      for (int s = 0; s < NS; s++) begin
        bit stable;
        p2[s] = p1[s];
        p1[s] = 0;
        rh[s][edge_n % HN] = (s < Z) ? bus.entry_raw[s] : bus.exit_raw[s-Z];
        stable = (edge_n - last_flip[s]) >= DEB;
        if (stable)
          for (int k = 0; k < DEB; k++) if (rh[s][(edge_n - k) % HN] == m_acc[s]) stable = 0;
        if (stable) begin
          m_acc[s] = ~m_acc[s];
          last_flip[s] = edge_n;
          p1[s] = m_acc[s];
        end
      end
    end
    #1;
    if (armed) begin
      int fl;
      fl = 1;
      for (int z = 0; z < Z; z++) begin
        chk($sformatf("count%0d", z), int'(bus.count[z*CW +: CW]), m_cnt[z]);
        chk($sformatf("free%0d", z), int'(bus.free[z*CW +: CW]), CAP - m_cnt[z]);
        chk($sformatf("full%0d", z), int'(bus.full[z]), int'(m_cnt[z] == CAP));
        chk($sformatf("empty%0d", z), int'(bus.empty[z]), int'(m_cnt[z] == 0));
        chk($sformatf("green%0d", z), int'(bus.green[z]), int'(m_cnt[z] != CAP));
        chk($sformatf("red%0d", z), int'(bus.red[z]), int'(m_cnt[z] == CAP));
        chk($sformatf("gate%0d", z), int'(bus.gate_open[z]), int'(edge_n < close_e[z]));
        chk($sformatf("reject%0d", z), int'(bus.reject[z]), int'(m_rej[z]));
        chk($sformatf("uflow%0d", z), int'(bus.underflow_err[z]), int'(m_err[z]));
        if (m_cnt[z] != CAP) fl = 0;
      end
      chk("lot_full", int'(bus.lot_full), fl);
    end
  end
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse(logic [Z-1:0] e, logic [Z-1:0] x);
    bus.entry_raw = e;
    bus.exit_raw = x;
    cyc(5);
    bus.entry_raw = '0;
    bus.exit_raw = '0;
    cyc(6);
  endtask
  initial begin
    int first_i, gcnt, rcnt;
    bus.entry_raw = '0;
    bus.exit_raw = '0;
    cyc(2);
    reset = 0;
    cyc(3);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_free", int'(bus.free), (20 << 5) | 20);
    chk("rst_empty", int'(bus.empty), 3);
    chk("rst_green", int'(bus.green), 3);
    chk("rst_red", int'(bus.red), 0);
    chk("rst_gate", int'(bus.gate_open), 0);
    // zone 0 entry held for 10 samples
    bus.entry_raw[0] = 1;
    first_i = -1;
    gcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (first_i < 0 && bus.count[CW-1:0] == 5'd1) first_i = i;
      gcnt += int'(bus.gate_open[0]);
      if (i == 9) bus.entry_raw[0] = 0;
    end
    chk("entry_latency", first_i, 5);
    chk("gate_len", gcnt, 8);
    chk("z1_untouched", int'(bus.count[2*CW-1:CW]), 0);
    bus.entry_raw[0] = 1;
    cyc(3);
    bus.entry_raw[0] = 0;
    cyc(10);
    chk("glitch_ignored", int'(bus.count[CW-1:0]), 1);
    pulse(2'b00, 2'b01);
    chk("exit_to_zero", int'(bus.count[CW-1:0]), 0);
    chk("no_err_yet", int'(bus.underflow_err), 0);
    pulse(2'b00, 2'b01);
    chk("uflow_set", int'(bus.underflow_err), 1);
    chk("uflow_count", int'(bus.count[CW-1:0]), 0);
    pulse(2'b01, 2'b00);
    chk("entry_after_err", int'(bus.count[CW-1:0]), 1);
    chk("uflow_sticky", int'(bus.underflow_err), 1);
    for (int k = 0; k < 20; k++) pulse(2'b10, 2'b00);
    chk("z1_count20", int'(bus.count[2*CW-1:CW]), 20);
    chk("z1_full", int'(bus.full[1]), 1);
    chk("z1_red", int'(bus.red[1]), 1);
    chk("z1_green", int'(bus.green[1]), 0);
    chk("z1_free0", int'(bus.free[2*CW-1:CW]), 0);
    cyc(10);
    bus.entry_raw[1] = 1;
    rcnt = 0;
    gcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rcnt += int'(bus.reject[1]);
      gcnt += int'(bus.gate_open[1]);
      if (i == 4) bus.entry_raw[1] = 0;
    end
    chk("z1_reject_pulse", rcnt, 1);
    chk("z1_reject_gate", gcnt, 0);
    chk("z1_reject_count", int'(bus.count[2*CW-1:CW]), 20);
    for (int k = 0; k < 19; k++) pulse(2'b01, 2'b00);
    chk("z0_count20", int'(bus.count[CW-1:0]), 20);
    chk("lot_full", int'(bus.lot_full), 1);
    cyc(10);
    bus.entry_raw[0] = 1;
    bus.exit_raw[0] = 1;
    rcnt = 0;
    gcnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rcnt += int'(bus.reject[0]);
      gcnt += int'(bus.gate_open[0]);
      if (i == 4) begin
        bus.entry_raw[0] = 0;
        bus.exit_raw[0] = 0;
      end
    end
    chk("simul_reject", rcnt, 0);
    chk("simul_gate", gcnt, 8);
    chk("simul_count", int'(bus.count[CW-1:0]), 20);
    chk("simul_uflow", int'(bus.underflow_err), 1);
    reset = 1;
    cyc(1);
    reset = 0;
    chk("rst2_count", int'(bus.count), 0);
    chk("rst2_uflow", int'(bus.underflow_err), 0);
    pulse(2'b00, 2'b01);
    for (int k = 0; k < 7; k++) pulse(2'b01, 2'b00);
    chk("pre_rst_count7", int'(bus.count[CW-1:0]), 7);
    chk("pre_rst_gate", int'(bus.gate_open[0]), 1);
    chk("pre_rst_uflow", int'(bus.underflow_err), 1);
    bus.entry_raw[0] = 1;
    reset = 1;
    cyc(1);
    chk("midrst_count", int'(bus.count[CW-1:0]), 0);
    chk("midrst_gate", int'(bus.gate_open[0]), 0);
    chk("midrst_uflow", int'(bus.underflow_err), 0);
    chk("midrst_free", int'(bus.free[CW-1:0]), 20);
    reset = 0;
    bus.entry_raw[0] = 0;
    cyc(10);
    chk("post_rst_count", int'(bus.count[CW-1:0]), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/parking_zone_ctrl.md
# parking_zone_ctrl

Parametrised multi-zone parking occupancy controller: the next generation of the fixed normal and handicapped parking counters. It supports ZONES independent zones, each with debounced entry and exit sensors, a saturating occupancy counter, and a timed entry-gate FSM. It also provides per-zone full/empty/reject/error status and green/red lamps. It sits between the raw lot sensors and the seven-segment display/lamp drivers of the top-level parking system.

## Interface
- ZONES, 2, number of independent zones (1..8); zone 0 = normal, zone 1 = handicapped by convention
- CNT_W, 5, occupancy counter width per zone
- CAPACITY, 20, spaces per zone; must satisfy 1 <= CAPACITY <= 2^CNT_W - 1
- DEB_CYCLES, 4, consecutive stable samples required to accept a sensor level change (>= 1)
- GATE_CYCLES, 8, cycles the entry gate stays open after an accepted entry (>= 1)

Ports:
- clk  in  1  sole clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears all state on the next rising edge
- entry_raw  in  ZONES  per-zone entry sensor level, already synchronous to clk
- exit_raw  in  ZONES  per-zone exit sensor level, already synchronous to clk
- count  out  ZONES*CNT_W  flattened occupancy; zone z at bits [z*CNT_W +: CNT_W]
- free  out  ZONES*CNT_W  flattened CAPACITY - count per zone
- full  out  ZONES  count == CAPACITY
- empty  out  ZONES  count == 0
- green  out  ZONES  = ~full
- red  out  ZONES  = full
- gate_open  out  ZONES  entry gate open
- reject  out  ZONES  1-cycle pulse: entry refused because the zone was full
- underflow_err  out  ZONES  sticky: exit seen while the zone was empty; cleared only by reset
- lot_full  out  1  AND of full[]

## Operation
- Debounce, per sensor (2*ZONES instances):
  - Holds an accepted level `acc` (reset 0) and a stability counter (reset 0).
  - If raw == acc, the counter clears.
  - Otherwise the counter increments. When it would reach DEB_CYCLES, acc takes raw and the counter clears.
  - Glitches shorter than DEB_CYCLES samples are ignored.
- Events: an entry/exit event is a registered 1-cycle pulse on the 0->1 transition of acc. A falling edge generates nothing.
- Occupancy update, per zone, evaluated on event pulses:
  - Entry only, not full: count+1 and gate start.
  - Entry only, full: count unchanged, reject pulses 1 cycle, gate stays in its current state.
  - Exit only, not empty: count-1.
  - Exit only, empty: count unchanged, underflow_err set.
  - Entry and exit in the same cycle: count unchanged. The entry is accepted (gate start, no reject) even when full; no error even when empty.
- Counter never exceeds CAPACITY and never wraps below 0.
- Gate FSM, per zone, states IDLE and OPEN with a timer:
  - IDLE -> OPEN on gate start; timer loads GATE_CYCLES.
  - OPEN: timer decrements each cycle; OPEN -> IDLE when it reaches 1 and decrements.
  - A gate start while OPEN reloads the timer to GATE_CYCLES.
  - gate_open = (state == OPEN).
- Zones are fully independent; lot_full, full, empty, green, red and free are combinational from the count registers.

## Timing
- Reset values: count 0, free CAPACITY, full 0, empty 1, green 1, red 0, gate_open 0, reject 0, underflow_err 0, lot_full 0 (unless CAPACITY logic makes it otherwise; with CAPACITY >= 1 it is 0). All debounce and FSM state is cleared.
- Latency, assuming raw rises before edge t and is held:
  - acc rises after edge t+DEB_CYCLES-1.
  - Event pulse registered at edge t+DEB_CYCLES.
  - count, gate_open and reject update at edge t+DEB_CYCLES+1.
- gate_open stays high for exactly GATE_CYCLES cycles after a single accepted entry.
- Reset asserted mid-operation overrides all events in that cycle. In-progress debounce counts and gate timers are discarded.
- A sensor held high produces exactly one event; a new event requires a debounced low, then a debounced high.

## Test plan
- Reset then idle: with ZONES=2, CAPACITY=20 -> count 0/0, free 20/20, empty=2'b11, green=2'b11, red=0, gate_open=0 on every cycle.
- Zone 0 entry held 10 cycles, DEB_CYCLES=4 -> count[0]=1 exactly 5 edges after the first high sample; gate_open[0] high 8 cycles; zone 1 unchanged. A 3-cycle glitch -> no change.
- 20 entries on zone 1 -> full[1]=1, red[1]=1, green[1]=0. The 21st entry -> reject[1] pulses 1 cycle, count stays 20, gate_open[1] stays 0.
- Exit on an empty zone 0 -> count 0, underflow_err[0]=1, held until reset; a subsequent entry still counts to 1.
- Simultaneous debounced entry and exit on zone 0 at count 20 -> count stays 20, no reject, gate_open[0] asserts. Both zones full -> lot_full=1.
- Reset asserted during an open gate with count 7 -> next edge count 0, gate_open 0, underflow_err cleared.
